// File: rtl/imem_loader.sv
// Writable 32-word instruction memory fed by a little-endian byte stream.
// The CPU stays stalled until a load completes; unwritten entries read as NOP.
module imem_loader #(
    parameter int          DEPTH     = 32,
    parameter logic [31:0] NOP_WORD  = 32'h0000_0013,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
    localparam int         AW        = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_start,
    input  logic          byte_valid,
    input  logic [7:0]    byte_data,
    output logic          byte_ready,
    output logic          load_done,
    output logic          cpu_stall,
    output logic [AW:0]   words_loaded,
    input  logic [AW-1:0] addr,
    output logic [31:0]   instr
);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t            state, state_d;
    logic [31:0]       mem [DEPTH];
    logic [DEPTH-1:0]  valid;
    logic [1:0]        byte_cnt;
    logic [AW-1:0]     wptr;
    logic [23:0]       asm_q;      // lanes 0..2; lane 3 comes straight from byte_data
    logic              accept, word_done, finish, clear;
    logic [31:0]       full_word;

    assign accept    = (state == LOAD) && byte_valid;
    assign word_done = accept && (byte_cnt == 2'd3);
    assign full_word = {byte_data, asm_q};
    assign finish    = word_done && ((full_word == HALT_WORD) || (wptr == AW'(DEPTH - 1)));
    assign clear     = load_start && (state != LOAD);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d    = state;
        byte_ready = 1'b0;
        load_done  = 1'b0;
        cpu_stall  = 1'b1;
        case (state)
            IDLE: if (load_start) state_d = LOAD;
            LOAD: begin
                byte_ready = 1'b1;
                if (finish) state_d = DONE;
            end
            DONE: begin
                load_done = 1'b1;
                cpu_stall = 1'b0;
                if (load_start) state_d = LOAD;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            valid        <= '0;
            byte_cnt     <= '0;
            wptr         <= '0;
            words_loaded <= '0;
            asm_q        <= '0;
        end else if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
                2'd0:    asm_q[7:0]   <= byte_data;
                2'd1:    asm_q[15:8]  <= byte_data;
                2'd2:    asm_q[23:16] <= byte_data;
                default: ;
            endcase
            if (word_done) begin
                valid[wptr]  <= 1'b1;
                wptr         <= wptr + 1'b1;
                words_loaded <= words_loaded + 1'b1;
            end
        end
    end

    // Array itself is not reset; the valid bits gate what the CPU sees.
    always_ff @(posedge clk) begin
        if (word_done) mem[wptr] <= full_word;
    end

    assign instr = valid[addr] ? mem[addr] : NOP_WORD;

endmodule
